// File: rtl/ext_sram_byte_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ext_sram_byte_bridge
// Purpose  : Splits one 32-bit OBI-style word request into a sequence of
//            8-bit accesses on the off-chip SRAM pins, handling byte-lane
//            sequencing, external read latency and read-word reassembly.
//            One transaction is outstanding at a time.
// Options  : `define EXT_SRAM_RD_SKIP_EN -> reads fetch only the lanes whose
//            byte enable is set; unread lanes return 0.
// Revision : 1.0 - initial release
// ============================================================================
module ext_sram_byte_bridge #(
   parameter int ADDR_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_i,
   output logic              gnt_o,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       wdata_i,
   output logic              rvalid_o,
   output logic [31:0]       rdata_o,
   output logic              busy_o,
   input  logic [7:0]        ext_sram_rdata_i,
   output logic [7:0]        ext_sram_wdata_o,
   output logic [ADDR_W-1:0] ext_sram_addr_o,
   output logic              ext_sram_read_o,
   output logic              ext_sram_write_o
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      WR       = 3'd3,
      DONE     = 3'd4
   } state_t;

   localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [3:0]          rem_q, rem_d;      // lanes still to be accessed
   logic [31:0]         wdata_q, wdata_d;
   logic [ADDR_W-3:0]   waddr_q, waddr_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [31:0]         hold_q, hold_d;

   logic [1:0]          lane;
   logic [3:0]          rem_clr;
   logic [3:0]          rd_mask;
   logic [3:0]          start_mask;

   // Address bits outside the word-aligned external window are don't-care.
   logic unused_addr;
   assign unused_addr = ^{addr_i[31:ADDR_W], addr_i[1:0]};

`ifdef EXT_SRAM_RD_SKIP_EN
   assign rd_mask = be_i;
`else
   assign rd_mask = 4'hF;
`endif

   assign start_mask = we_i ? be_i : rd_mask;

   // Current lane is the lowest lane still pending, giving ascending order
   // and zero-cycle skipping of disabled lanes.
   always_comb begin
      lane = 2'd0;
      if (rem_q[0])      lane = 2'd0;
      else if (rem_q[1]) lane = 2'd1;
      else if (rem_q[2]) lane = 2'd2;
      else if (rem_q[3]) lane = 2'd3;
   end

   assign rem_clr         = rem_q & ~(4'b0001 << lane);
   assign ext_sram_addr_o = {waddr_q, lane};

   // Next-state, datapath updates and all handshake/strobe outputs.
   always_comb begin
      state_d          = state_q;
      we_d             = we_q;
      rem_d            = rem_q;
      wdata_d          = wdata_q;
      waddr_d          = waddr_q;
      cnt_d            = cnt_q;
      hold_d           = hold_q;
      gnt_o            = 1'b0;
      rvalid_o         = 1'b0;
      rdata_o          = 32'h0;
      busy_o           = (state_q != IDLE);
      ext_sram_read_o  = 1'b0;
      ext_sram_write_o = 1'b0;
      ext_sram_wdata_o = 8'h00;
      case (state_q)
         IDLE: begin
            // Masked by reset so the arbiter never sees a grant that is dropped.
            gnt_o = req_i & rst_ni;
            if (req_i) begin
               we_d    = we_i;
               wdata_d = wdata_i;
               waddr_d = addr_i[ADDR_W-1:2];
               rem_d   = start_mask;
               hold_d  = 32'h0;
               if (start_mask == 4'h0) state_d = DONE;
               else if (we_i)          state_d = WR;
               else                    state_d = RD_ISSUE;
            end
         end
         RD_ISSUE: begin
            ext_sram_read_o = 1'b1;
            cnt_d           = LAT_INIT;
            state_d         = RD_WAIT;
         end
         RD_WAIT: begin
            // Count 1 marks the cycle in which the SRAM data is valid.
            if (cnt_q == 2'd1) begin
               case (lane)
                  2'd0:    hold_d[7:0]   = ext_sram_rdata_i;
                  2'd1:    hold_d[15:8]  = ext_sram_rdata_i;
                  2'd2:    hold_d[23:16] = ext_sram_rdata_i;
                  default: hold_d[31:24] = ext_sram_rdata_i;
               endcase
               rem_d   = rem_clr;
               state_d = (rem_clr == 4'h0) ? DONE : RD_ISSUE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         WR: begin
            ext_sram_write_o = 1'b1;
            case (lane)
               2'd0:    ext_sram_wdata_o = wdata_q[7:0];
               2'd1:    ext_sram_wdata_o = wdata_q[15:8];
               2'd2:    ext_sram_wdata_o = wdata_q[23:16];
               default: ext_sram_wdata_o = wdata_q[31:24];
            endcase
            rem_d   = rem_clr;
            state_d = (rem_clr == 4'h0) ? DONE : WR;
         end
         DONE: begin
            rvalid_o = 1'b1;
            rdata_o  = we_q ? 32'h0 : hold_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         rem_q   <= 4'h0;
         wdata_q <= 32'h0;
         waddr_q <= '0;
         cnt_q   <= 2'd0;
         hold_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         rem_q   <= rem_d;
         wdata_q <= wdata_d;
         waddr_q <= waddr_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ext_sram_byte_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_sram_byte_bridge
// Purpose  : Self-checking bench for ext_sram_byte_bridge (default build).
//            Two instances: RD_LAT=1 (main) and RD_LAT=3 (latency check),
//            each attached to a behavioural byte SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_sram_byte_bridge;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req1 = 1'b0, req3 = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  be = 4'h0;
   logic [31:0] addr = 32'h0, wdata = 32'h0;

   logic        gnt1, rvalid1, busy1, rd1, wr1;
   logic [31:0] rdata1;
   logic [7:0]  wd1, srd1;
   logic [15:0] a1;
   logic        gnt3, rvalid3, busy3, rd3, wr3;
   logic [31:0] rdata3;
   logic [7:0]  wd3, srd3;
   logic [15:0] a3;

   ext_sram_byte_bridge #(.ADDR_W(16), .RD_LAT(1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_ni), .req_i(req1), .gnt_o(gnt1), .we_i(we),
      .be_i(be), .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid1),
      .rdata_o(rdata1), .busy_o(busy1), .ext_sram_rdata_i(srd1),
      .ext_sram_wdata_o(wd1), .ext_sram_addr_o(a1),
      .ext_sram_read_o(rd1), .ext_sram_write_o(wr1));

   ext_sram_byte_bridge #(.ADDR_W(16), .RD_LAT(3)) u_dut3 (
      .clk_i(clk), .rst_ni(rst_ni), .req_i(req3), .gnt_o(gnt3), .we_i(we),
      .be_i(be), .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid3),
      .rdata_o(rdata3), .busy_o(busy3), .ext_sram_rdata_i(srd3),
      .ext_sram_wdata_o(wd3), .ext_sram_addr_o(a3),
      .ext_sram_read_o(rd3), .ext_sram_write_o(wr3));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- SRAM model ----------------
   bit [7:0]  mem [65536];
   bit        mem_init = 1'b0;
   bit        p1_v;
   bit [15:0] p1_a;
   bit        p3_v [3];
   bit [15:0] p3_a [3];

   always @(posedge clk) begin
      if (!mem_init) begin
         mem[16'h0104] <= 8'h11; mem[16'h0105] <= 8'h22;
         mem[16'h0106] <= 8'h33; mem[16'h0107] <= 8'h44;
         mem[16'h0200] <= 8'h01; mem[16'h0201] <= 8'h02;
         mem[16'h0202] <= 8'h03; mem[16'h0203] <= 8'h04;
         mem[16'h0008] <= 8'h5A; mem[16'h0009] <= 8'h6B;
         mem[16'h000A] <= 8'h7C; mem[16'h000B] <= 8'h8D;
         mem_init <= 1'b1;
      end else begin
         if (wr1) mem[a1] <= wd1;
         if (wr3) mem[a3] <= wd3;
      end
      p1_v    <= rd1;  p1_a    <= a1;
      p3_v[0] <= rd3;  p3_a[0] <= a3;
      p3_v[1] <= p3_v[0]; p3_a[1] <= p3_a[0];
      p3_v[2] <= p3_v[1]; p3_a[2] <= p3_a[1];
   end

   // Junk value outside the valid data window exposes mistimed sampling.
   assign srd1 = p1_v    ? mem[p1_a]    : 8'hEE;
   assign srd3 = p3_v[2] ? mem[p3_a[2]] : 8'hEE;

   // ---------------- checking infrastructure ----------------
   int n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct { logic [31:0] rdata; int cyc; } exp_t;
   exp_t sb[$];

   typedef struct { int cyc; bit rd; bit wr; bit [15:0] addr; bit [7:0] data; } strobe_t;
   strobe_t slog[$];

   bit mon_en = 1'b0;

   // Main-instance monitor: scoreboard pop on rvalid, strobe log, protocol rules.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rvalid1) begin
            chk("rvalid_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("rdata", rdata1, e.rdata);
               chk("rvalid_cycle", cyc, e.cyc);
            end
         end
         if (rd1 || wr1) slog.push_back('{cyc, rd1, wr1, a1, wd1});
         chk("rd_wr_exclusive", 32'(rd1 & wr1), 32'd0);
         if (!wr1) chk("wdata_idle_zero", 32'(wd1), 32'd0);
         chk("gnt_while_busy", 32'(gnt1 & busy1), 32'd0);
      end
   end

   task automatic wait_gnt(output int g, output bit ok);
      ok = 1'b0;
      g  = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (gnt1) begin
            g  = cyc;
            ok = 1'b1;
            break;
         end
      end
      chk("gnt_seen", 32'(ok), 32'd1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", sb.size(), 0);
      sb.delete();
   endtask

   typedef struct {
      bit        we;
      bit [3:0]  be;
      bit [31:0] addr;
      bit [31:0] wdata;
      bit [31:0] rdata;
      int        lat;
      int        nstr;
      bit [15:0] addr0;
      bit [7:0]  data0;
   } vec_t;

   task automatic issue(input vec_t v, output int g);
      bit ok;
      slog.delete();
      @(posedge clk); #1;
      we = v.we; be = v.be; addr = v.addr; wdata = v.wdata; req1 = 1'b1;
      wait_gnt(g, ok);
      if (ok) sb.push_back('{v.rdata, g + v.lat});
      @(posedge clk); #1;
      req1 = 1'b0;
   endtask

   vec_t tbl[12];

   initial begin
      int   g, g2;
      bit   ok;

      // we be      addr          wdata         rdata         lat nstr addr0    data0
      tbl[0]  = '{0, 4'hF, 32'h0000_0104, 32'h0,        32'h4433_2211, 9, 4, 16'h0104, 8'h00};
      tbl[1]  = '{1, 4'hA, 32'h0000_0200, 32'hAABB_CCDD, 32'h0,        3, 2, 16'h0201, 8'hCC};
      tbl[2]  = '{1, 4'h0, 32'h0000_0300, 32'hFFFF_FFFF, 32'h0,        1, 0, 16'h0000, 8'h00};
      tbl[3]  = '{0, 4'hF, 32'h0000_0200, 32'h0,        32'hAA03_CC01, 9, 4, 16'h0200, 8'h00};
      tbl[4]  = '{0, 4'hF, 32'h1234_000B, 32'h0,        32'h8D7C_6B5A, 9, 4, 16'h0008, 8'h00};
      tbl[5]  = '{1, 4'hF, 32'h0000_0400, 32'h1234_5678, 32'h0,        5, 4, 16'h0400, 8'h78};
      tbl[6]  = '{0, 4'h0, 32'h0000_0400, 32'h0,        32'h1234_5678, 9, 4, 16'h0400, 8'h00};
      tbl[7]  = '{1, 4'h1, 32'h0000_0404, 32'hDEAD_BEEF, 32'h0,        2, 1, 16'h0404, 8'hEF};
      tbl[8]  = '{1, 4'h8, 32'h0000_0404, 32'hCAFE_0000, 32'h0,        2, 1, 16'h0407, 8'hCA};
      tbl[9]  = '{0, 4'h5, 32'h0000_0404, 32'h0,        32'hCA00_00EF, 9, 4, 16'h0404, 8'h00};
      tbl[10] = '{1, 4'h6, 32'h0000_0500, 32'h1122_3344, 32'h0,        3, 2, 16'h0501, 8'h33};
      tbl[11] = '{0, 4'hF, 32'h0000_0500, 32'h0,        32'h0022_3300, 9, 4, 16'h0500, 8'h00};

      // ---- reset state ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt",    32'(gnt1),    32'd0);
      chk("rst_rvalid", 32'(rvalid1), 32'd0);
      chk("rst_busy",   32'(busy1),   32'd0);
      chk("rst_read",   32'(rd1),     32'd0);
      chk("rst_write",  32'(wr1),     32'd0);
      chk("rst_rdata",  rdata1,       32'd0);
      chk("rst_wdata",  32'(wd1),     32'd0);
      chk("rst_addr",   32'(a1),      32'd0);
      @(posedge clk); #1;
      rst_ni = 1'b1;
      mon_en = 1'b1;

      // ---- table-driven transactions ----
      for (int t = 0; t < 12; t++) begin
         issue(tbl[t], g);
         wait_done();
         chk("strobe_count", slog.size(), tbl[t].nstr);
         if (slog.size() != 0) begin
            chk("strobe0_addr", 32'(slog[0].addr), 32'(tbl[t].addr0));
            chk("strobe0_data", 32'(slog[0].data), 32'(tbl[t].data0));
         end
         for (int i = 0; i < slog.size() && i < tbl[t].nstr; i++) begin
            chk("strobe_cycle", slog[i].cyc, g + 1 + (tbl[t].we ? i : 2 * i));
            chk("strobe_kind", {30'd0, slog[i].rd, slog[i].wr},
                tbl[t].we ? 32'd1 : 32'd2);
         end
      end

      // Write with be=1010 must leave the disabled lanes untouched.
      chk("mem_200", 32'(mem[16'h0200]), 32'h01);
      chk("mem_201", 32'(mem[16'h0201]), 32'hCC);
      chk("mem_202", 32'(mem[16'h0202]), 32'h03);
      chk("mem_203", 32'(mem[16'h0203]), 32'hAA);
      chk("mem_203_second", 32'(slog.size()), 32'd4);

      // ---- back-to-back with req held high ----
      @(posedge clk); #1;
      we = 1'b0; be = 4'hF; addr = 32'h0000_0104; req1 = 1'b1;
      wait_gnt(g, ok);
      if (ok) sb.push_back('{32'h4433_2211, g + 9});
      @(posedge clk); #1;
      we = 1'b1; be = 4'hF; addr = 32'h0000_0600; wdata = 32'h0BAD_F00D;
      wait_gnt(g2, ok);
      chk("b2b_second_gnt_cycle", g2, g + 10);
      if (ok) sb.push_back('{32'h0, g2 + 5});
      @(posedge clk); #1;
      req1 = 1'b0;
      wait_done();
      chk("b2b_mem_600", 32'(mem[16'h0600]), 32'h0D);
      chk("b2b_mem_603", 32'(mem[16'h0603]), 32'h0B);

      // ---- reset in cycle G+4 of a read ----
      @(posedge clk); #1;
      we = 1'b0; be = 4'hF; addr = 32'h0000_0104; req1 = 1'b1;
      wait_gnt(g, ok);
      @(posedge clk); #1;
      req1 = 1'b0;
      while (cyc < g + 4) begin
         @(posedge clk); #1;
      end
      rst_ni = 1'b0;
      @(posedge clk); #1;
      rst_ni = 1'b1;
      slog.delete();
      @(negedge clk);
      chk("abort_busy",   32'(busy1),   32'd0);
      chk("abort_rvalid", 32'(rvalid1), 32'd0);
      chk("abort_strobe", 32'(rd1 | wr1), 32'd0);
      chk("abort_gnt",    32'(gnt1),    32'd0);
      chk("abort_rdata",  rdata1,       32'd0);
      chk("abort_wdata",  32'(wd1),     32'd0);
      chk("abort_addr",   32'(a1),      32'd0);
      repeat (12) @(negedge clk);
      chk("abort_no_strobes", slog.size(), 0);
      issue(tbl[0], g);
      wait_done();
      chk("post_abort_strobes", slog.size(), 4);

      // ---- RD_LAT=3 read latency ----
      @(posedge clk); #1;
      we = 1'b0; be = 4'hF; addr = 32'h0000_0104; req3 = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (gnt3) begin g = cyc; ok = 1'b1; break; end
      end
      chk("lat3_gnt_seen", 32'(ok), 32'd1);
      @(posedge clk); #1;
      req3 = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (rvalid3) begin g2 = cyc; ok = 1'b1; break; end
      end
      chk("lat3_rvalid_seen", 32'(ok), 32'd1);
      chk("lat3_rvalid_cycle", g2, g + 17);
      chk("lat3_rdata", rdata3, 32'h4433_2211);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1);
   end

endmodule
`default_nettype wire
